// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_D,
        BUSY_I,
        RESP
    } arb_state_t;

    // Bit positions inside the pipeline stall vector
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;

    localparam logic [5:0] NOP_OPCODE = 6'd63;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the memory model (slave).
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/unified_mem_arbiter_timeout_counter.sv
// Counts busy cycles without an ack; tc flags the cycle in which the count reaches TIMEOUT.
module arb_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic Clk,
    input  logic Rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // tc fires on the increment that would make the count equal TIMEOUT
    assign tc = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and data ports onto one variable-latency memory and drives pipeline stalls.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_err,

    unified_mem_arbiter_if.master mem,

    output logic [3:0]        stall,
    output logic              if_nop
);

    arb_state_t state;
    logic       busy;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_tc;

    assign busy       = (state == BUSY_D) || (state == BUSY_I);
    assign tmo_clear  = !busy;
    assign tmo_enable = busy && !mem.mem_ack;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .tc     (tmo_tc)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            if_rdata      <= '0;
            if_done       <= 1'b0;
            if_err        <= 1'b0;
            dm_rdata      <= '0;
            dm_done       <= 1'b0;
            dm_err        <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Data is the older instruction, so it wins a simultaneous request
                    if (dm_req) begin
                        state         <= BUSY_D;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= dm_we;
                        mem.mem_addr  <= dm_addr;
                        mem.mem_wdata <= dm_wdata;
                    end else if (if_req) begin
                        state        <= BUSY_I;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= if_addr;
                    end
                end
                BUSY_D, BUSY_I: begin
                    // An ack in the timeout cycle still completes the access normally
                    if (mem.mem_ack || tmo_tc) begin
                        state       <= RESP;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        if (state == BUSY_D) begin
                            dm_done  <= 1'b1;
                            dm_rdata <= mem.mem_ack ? mem.mem_rdata : '0;
                            if (!mem.mem_ack) dm_err <= 1'b1;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem.mem_ack ? mem.mem_rdata : '0;
                            if (!mem.mem_ack) if_err <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall bits are OR-ed with the hazard unit downstream, so they must read 0 under reset
    always_comb begin
        stall  = '0;
        if_nop = 1'b0;
        if (!Rst) begin
            if (dm_req && !dm_done) begin
                stall[STALL_PC]     = 1'b1;
                stall[STALL_IF_ID]  = 1'b1;
                stall[STALL_ID_EX]  = 1'b1;
                stall[STALL_EX_MEM] = 1'b1;
            end else if (if_req && !if_done) begin
                stall[STALL_PC] = 1'b1;
                if_nop          = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor checks done/stall, a memory model checks the bus.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_done, dm_done, if_err, dm_err;
    logic [3:0]  stall;
    logic        if_nop;

    unified_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mb ();

    unified_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
        .mem(mb), .stall(stall), .if_nop(if_nop)
    );

    always #5 Clk = ~Clk;

    typedef struct { bit chk_rdata; logic [31:0] rdata; logic err; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } op_t;

    resp_t if_q[$];
    resp_t dm_q[$];
    op_t   if_ops[$];
    op_t   dm_ops[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    int checks = 0;
    int errors = 0;
    bit if_err_m = 0;
    bit dm_err_m = 0;
    int force_lat = -1;

    // Addresses with bit 31 set are unmapped: the memory model never acks them
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_fetch(input logic [31:0] a);
        resp_t r;
        op_t   o;
        int    n;
        if (a[31]) if_err_m = 1;
        r.chk_rdata = 1;
        r.rdata     = a[31] ? 32'h0 : ref_rd(a);
        r.err       = if_err_m;
        if_q.push_back(r);
        o.we = 1'b0; o.addr = a; o.wdata = 32'h0;
        if_ops.push_back(o);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!if_done && n < 200);
        chk("if_done within bound", {31'h0, if_done}, 32'h1);
        @(posedge Clk);
        #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        resp_t r;
        op_t   o;
        int    n;
        if (a[31]) dm_err_m = 1;
        r.chk_rdata = a[31] || !we;
        r.rdata     = a[31] ? 32'h0 : ref_rd(a);
        r.err       = dm_err_m;
        if (we && !a[31]) ref_mem[a] = wd;
        dm_q.push_back(r);
        o.we = we; o.addr = a; o.wdata = wd;
        dm_ops.push_back(o);
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!dm_done && n < 200);
        chk("dm_done within bound", {31'h0, dm_done}, 32'h1);
        @(posedge Clk);
        #1;
        dm_req = 1'b0;
    endtask

    // Memory model: checks grant priority and bus stability, acks after a chosen latency
    initial begin
        bit          active, dead;
        int          lat, held;
        logic        dm_pre;
        logic [31:0] a0, d0;
        logic        w0;
        op_t         o;
        active = 0; dead = 0; lat = 0; held = 0;
        a0 = 0; d0 = 0; w0 = 0;
        mb.mem_ack   = 1'b0;
        mb.mem_rdata = 32'h0;
        forever begin
            @(posedge Clk);
            dm_pre = dm_req;
            #1;
            mb.mem_ack = 1'b0;
            if (Rst) begin
                active = 0;
            end else if (mb.mem_req) begin
                if (!active) begin
                    active = 1; held = 0;
                    a0 = mb.mem_addr; w0 = mb.mem_we; d0 = mb.mem_wdata;
                    dead = a0[31];
                    lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 4);
                    if (dm_pre) begin
                        chk("data grant expected", 32'(dm_ops.size() != 0), 32'h1);
                        if (dm_ops.size() != 0) begin
                            o = dm_ops.pop_front();
                            chk("dm mem_addr", a0, o.addr);
                            chk("dm mem_we", {31'h0, w0}, {31'h0, o.we});
                            if (o.we) chk("dm mem_wdata", d0, o.wdata);
                        end
                    end else begin
                        chk("fetch grant expected", 32'(if_ops.size() != 0), 32'h1);
                        if (if_ops.size() != 0) begin
                            o = if_ops.pop_front();
                            chk("if mem_addr", a0, o.addr);
                            chk("if mem_we", {31'h0, w0}, 32'h0);
                        end
                    end
                end else begin
                    chk("mem_addr stable", mb.mem_addr, a0);
                    chk("mem_we stable", {31'h0, mb.mem_we}, {31'h0, w0});
                    if (w0) chk("mem_wdata stable", mb.mem_wdata, d0);
                end
                held++;
                if (!dead && held == lat + 1) begin
                    mb.mem_ack = 1'b1;
                    if (w0) begin
                        slv_mem[a0] = d0;
                        mb.mem_rdata = $urandom;
                    end else begin
                        mb.mem_rdata = slv_rd(a0);
                    end
                end
            end else if (active) begin
                active = 0;
                chk("mem_req held cycles", 32'(held), dead ? 32'(TIMEOUT) : 32'(lat + 1));
            end
        end
    end

    // Monitor: stall rules every cycle, responses popped on each done pulse
    initial begin
        resp_t      r;
        logic [3:0] exp_stall;
        logic       exp_nop;
        forever begin
            @(negedge Clk);
            exp_stall = 4'b0000;
            exp_nop   = 1'b0;
            if (!Rst) begin
                if (dm_req && !dm_done) exp_stall = 4'b1111;
                else if (if_req && !if_done) begin
                    exp_stall = 4'b0001;
                    exp_nop   = 1'b1;
                end
            end
            chk("stall", {28'h0, stall}, {28'h0, exp_stall});
            chk("if_nop", {31'h0, if_nop}, {31'h0, exp_nop});
            if (if_done) begin
                chk("if_done has pending fetch", 32'(if_q.size() != 0), 32'h1);
                if (if_q.size() != 0) begin
                    r = if_q.pop_front();
                    if (r.chk_rdata) chk("if_rdata", if_rdata, r.rdata);
                    chk("if_err", {31'h0, if_err}, {31'h0, r.err});
                end
            end
            if (dm_done) begin
                chk("dm_done has pending access", 32'(dm_q.size() != 0), 32'h1);
                if (dm_q.size() != 0) begin
                    r = dm_q.pop_front();
                    if (r.chk_rdata) chk("dm_rdata", dm_rdata, r.rdata);
                    chk("dm_err", {31'h0, dm_err}, {31'h0, r.err});
                end
            end
        end
    end

    initial begin
        op_t o;
        Rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
        ref_mem[32'h40]  = 32'h8C220004; slv_mem[32'h40]  = 32'h8C220004;
        ref_mem[32'h100] = 32'h5;        slv_mem[32'h100] = 32'h5;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset mem_req", {31'h0, mb.mem_req}, 32'h0);
        chk("reset mem_we", {31'h0, mb.mem_we}, 32'h0);
        chk("reset mem_addr", mb.mem_addr, 32'h0);
        chk("reset done", {30'h0, if_done, dm_done}, 32'h0);
        chk("reset err", {30'h0, if_err, dm_err}, 32'h0);
        chk("reset rdata", if_rdata | dm_rdata, 32'h0);
        Rst = 1'b0;

        force_lat = 1;
        do_fetch(32'h40);
        force_lat = -1;

        fork
            do_fetch(32'h44);
            do_data(1'b0, 32'h100, 32'h0);
        join

        force_lat = 3;
        fork
            do_fetch(32'h48);
            begin
                repeat (2) @(posedge Clk);
                #1;
                do_data(1'b0, 32'h104, 32'h0);
            end
        join
        force_lat = -1;

        do_data(1'b1, 32'h10, 32'hDEADBEEF);
        do_data(1'b0, 32'h10, 32'h0);

        do_fetch(32'h8000_0040);
        do_fetch(32'h40);

        force_lat = TIMEOUT - 1;
        do_data(1'b0, 32'h104, 32'h0);
        force_lat = -1;
        do_data(1'b0, 32'h8000_0100, 32'h0);
        do_data(1'b1, 32'h8000_0104, 32'h1);

        o.we = 1'b0; o.addr = 32'h8000_0200; o.wdata = 32'h0;
        dm_ops.push_back(o);
        dm_we = 1'b0; dm_addr = 32'h8000_0200; dm_req = 1'b1;
        repeat (4) @(posedge Clk);
        #2;
        Rst = 1'b1;
        #1;
        chk("mid-reset mem_req", {31'h0, mb.mem_req}, 32'h0);
        chk("mid-reset stall", {28'h0, stall}, 32'h0);
        chk("mid-reset dm_done", {31'h0, dm_done}, 32'h0);
        chk("mid-reset err", {30'h0, if_err, dm_err}, 32'h0);
        dm_req = 1'b0;
        if_err_m = 0;
        dm_err_m = 0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        fork
            for (int i = 0; i < 30; i++) begin
                int          gap;
                logic [31:0] a;
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    repeat (gap) @(posedge Clk);
                    #1;
                end
                a = {20'h0, 10'($urandom), 2'b00};
                if ($urandom_range(0, 11) == 0) a[31] = 1'b1;
                do_fetch(a);
            end
            for (int j = 0; j < 30; j++) begin
                int          gap;
                logic [31:0] a;
                gap = $urandom_range(0, 3);
                if (gap > 0) begin
                    repeat (gap) @(posedge Clk);
                    #1;
                end
                a = 32'h1000 | {22'h0, 8'($urandom), 2'b00};
                if ($urandom_range(0, 11) == 0) a[31] = 1'b1;
                do_data(1'($urandom), a, $urandom);
            end
        join

        repeat (5) @(posedge Clk);
        #1;
        chk("fetch responses drained", 32'(if_q.size()), 32'h0);
        chk("data responses drained", 32'(dm_q.size()), 32'h0);
        chk("fetch grants drained", 32'(if_ops.size()), 32'h0);
        chk("data grants drained", 32'(dm_ops.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch port and the data-memory port of the 5-stage pipelined MIPS core.
- Sequences each access with a req/ack handshake and returns a one-cycle done pulse to the requester.
- Drives the pipeline stall vector and the IF/ID NOP-insert while an access is outstanding.
- Sits between the IF/MEM stages and the memory model, beside the hazard unit and the pipeline register controller; its stall bits are OR-ed with theirs.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before the access is aborted.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_done
- if_done  out  1  one-cycle fetch completion
- if_err  out  1  sticky fetch timeout error
- dm_req  in  1  data request, level, held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_done
- dm_done  out  1  one-cycle data completion
- dm_err  out  1  sticky data timeout error
- mem_req  out  1  memory request, held until mem_ack or timeout
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion
- stall  out  4  {EX_MEM, ID_EX, IF_ID, PC} hold bits
- if_nop  out  1  load NOP into IF/ID

Behaviour:
- Reset: Rst is asynchronous, active-high; clock is Clk.
  - All outputs are 0 on reset.
  - FSM goes to IDLE and the timeout counter clears.
  - A reset in the middle of an access drops mem_req immediately. No done is produced for that access.
- FSM states: IDLE, BUSY_D, BUSY_I, RESP.
- IDLE:
  - If dm_req: latch dm_addr, dm_we and dm_wdata; go to BUSY_D.
  - Else if if_req: latch if_addr; go to BUSY_I (mem_we = 0).
  - When both requests are present, data wins because it is the older instruction.
- BUSY_x:
  - mem_req = 1, with registered, stable mem_addr, mem_we and mem_wdata.
  - On mem_ack: capture mem_rdata into the matching rdata register; go to RESP.
  - There is no preemption. A dm_req arriving during BUSY_I waits until the fetch completes.
- RESP:
  - Assert the matching done for exactly 1 cycle; mem_req = 0.
  - Next state is IDLE.
  - The requester must drop or replace its req by the cycle after done. Requests are not sampled in RESP.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req at N+1.
  - mem_ack at cycle M gives done at M+1 and IDLE at M+2.
  - Minimum is 3 cycles, with zero-wait ack at N+1.
- rdata holds its last captured value until the next capture.
  - Stores also capture mem_rdata; consumers ignore it.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop mem_req, load rdata with 0, go to RESP (done still pulses), and set the matching sticky err.
  - The err bits clear only on Rst.
  - An ack arriving in the same cycle as the timeout wins: the access completes normally and no error is set.
- Stall (combinational):
  - While (dm_req && !dm_done): stall = 4'b1111, if_nop = 0. The whole pipeline freezes.
  - Else while (if_req && !if_done): stall = 4'b0001, if_nop = 1. PC holds and a bubble enters ID; later stages drain.
  - Otherwise stall = 4'b0000.
- Single outstanding access only; no buffering or queue.

Decomposition:
- Shared package contents:
  - FSM state enum (IDLE/BUSY_D/BUSY_I/RESP).
  - Stall-vector bit positions: PC = 0, IF_ID = 1, ID_EX = 2, EX_MEM = 3.
  - The NOP opcode constant 6'd63.
- One sub-module, arb_timeout_counter: clear, enable, terminal-count output, parameterised by TIMEOUT.

Test Plan:
- Fetch only, if_addr = 0x40, ack after 2 cycles with rdata 0x8C220004 -> mem_req 2 cycles; if_done 1 cycle with if_rdata = 0x8C220004; stall = 0001 and if_nop = 1 until done.
- Simultaneous if_req and dm_req (load 0x100, ack rdata 0x5) -> data served first with dm_rdata = 0x5 and stall = 1111; fetch granted the cycle after RESP.
- dm_req raised during BUSY_I -> fetch completes unpreempted; data then granted; stall switches from 0001 to 1111.
- Store, dm_we = 1, addr 0x10, wdata 0xDEADBEEF -> mem_we = 1, mem_addr = 0x10, mem_wdata = 0xDEADBEEF stable until ack; dm_done pulses.
- No ack for 15 cycles on a fetch -> mem_req drops, if_done pulses with if_rdata = 0, if_err = 1 sticky; next access still works.
- Rst asserted mid-BUSY_D -> mem_req, stall, done and err all 0 immediately; FSM in IDLE.
